// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed N-digit 7-segment driver.
// Latches a packed hex word and scans the digits with a programmable slot
// length and a per-slot dead time (anti-ghosting). It supports a decimal point
// and a blank control for each digit, leading-zero suppression, and selectable
// segment and digit polarity.
module seg7_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD           = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int LZ_SUPPRESS    = 1,
    localparam int IW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig,
    output logic [IW-1:0]         scan_idx
);

    localparam int CW = $clog2(CLK_DIV);

    // Pin levels that mean "off" for each polarity choice.
    localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]       cnt_q;
    logic [4*DIGITS-1:0] data_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   blank_q;

    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   dig_d;

    logic                wrap;
    assign wrap = (cnt_q == CW'(CLK_DIV - 1));

    // Active-high hex font, bit 6 = segment a.
    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] f;
        unique case (v)
            4'h0: f = 7'h7E;
            4'h1: f = 7'h30;
            4'h2: f = 7'h6D;
            4'h3: f = 7'h79;
            4'h4: f = 7'h33;
            4'h5: f = 7'h5B;
            4'h6: f = 7'h5F;
            4'h7: f = 7'h70;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h7B;
            4'hA: f = 7'h77;
            4'hB: f = 7'h1F;
            4'hC: f = 7'h4E;
            4'hD: f = 7'h3D;
            4'hE: f = 7'h4F;
            default: f = 7'h47;
        endcase
        return f;
    endfunction

    // Prescaler and slot index: free-running, independent of load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            scan_idx <= '0;
        end else if (wrap) begin
            cnt_q    <= '0;
            scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end else begin
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    // Shadow registers, captured only on a load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            data_q  <= data;
            dp_q    <= dp_in;
            blank_q <= blank;
        end
    end

    // Next pin values for the current slot, from the present shadow and scan state.
    always_comb begin
        logic [3:0] nib;
        logic       sel_dp;
        logic       sel_blank;
        logic       lead;
        logic       sel_lead;
        logic       dark;
        logic [6:0] seg_ah;
        logic       dp_ah;
        logic [DIGITS-1:0] dig_ah;

        nib       = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        sel_lead  = 1'b0;
        dig_ah    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_ah[k] = (scan_idx == IW'(k));
            if (scan_idx == IW'(k)) begin
                nib       = data_q[4*k +: 4];
                sel_dp    = dp_q[k];
                sel_blank = blank_q[k];
            end
        end

        // A digit is a leading zero when it and every digit above it hold
        // zero with no decimal point requested; digit 0 is never suppressed.
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead = lead & (data_q[4*k +: 4] == 4'h0) & ~dp_q[k];
            if (scan_idx == IW'(k)) begin
                sel_lead = lead;
            end
        end

        dark   = sel_blank | ((LZ_SUPPRESS != 0) & sel_lead);
        seg_ah = dark ? 7'h00 : font(nib);
        dp_ah  = ~dark & sel_dp;

        if (cnt_q < CW'(DEAD)) begin
            seg_ah = '0;
            dp_ah  = 1'b0;
            dig_ah = '0;
        end

        seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
        dp_d  = (SEG_ACTIVE_LOW != 0) ? ~dp_ah : dp_ah;
        dig_d = (DIG_ACTIVE_LOW != 0) ? ~dig_ah : dig_ah;
    end

    // Output pin registers; reset forces every pin inactive at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            dig <= DIG_OFF;
        end else begin
            seg <= seg_d;
            dp  <= dp_d;
            dig <= dig_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed plus randomized bench for seg7_scan.
// Two instances share their inputs. One uses active-low pins and the other
// uses active-high pins. A slot-arithmetic reference model predicts both.
module tb_seg7_scan;

    localparam int D   = 4;
    localparam int DIV = 8;
    localparam int DT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  dig_a, dig_b;
    logic [1:0]  idx_a, idx_b;

    int checks = 0;
    int failures = 0;

    seg7_scan #(
        .DIGITS(D), .CLK_DIV(DIV), .DEAD(DT),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
    ) dut_lo (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blank(blank),
        .seg(seg_a), .dp(dp_a), .dig(dig_a), .scan_idx(idx_a)
    );

    seg7_scan #(
        .DIGITS(D), .CLK_DIV(DIV), .DEAD(DT),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .LZ_SUPPRESS(1)
    ) dut_hi (
        .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blank(blank),
        .seg(seg_b), .dp(dp_b), .dig(dig_b), .scan_idx(idx_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // Active-high {dig, dp, seg} for the clock period after `t` edges since reset.
    function automatic logic [11:0] expect_at(input int t, input logic [15:0] d,
                                              input logic [3:0] p, input logic [3:0] b);
        int  cnt;
        int  idx;
        bit  lead;
        bit  dark;
        logic [3:0] dg;
        logic [6:0] s;
        logic       pt;
        cnt = t % DIV;
        idx = (t / DIV) % D;
        if (cnt < DT) return 12'h000;
        lead = 1'b1;
        for (int k = idx; k < D; k++) begin
            if (d[4*k +: 4] != 4'h0 || p[k]) lead = 1'b0;
        end
        dark = b[idx] || (idx != 0 && lead);
        dg = 4'(1 << idx);
        s  = dark ? 7'h00 : font(d[4*idx +: 4]);
        pt = dark ? 1'b0 : p[idx];
        return {dg, pt, s};
    endfunction

    int          n;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_dig;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0; m_data <= '0; m_dp <= '0; m_blank <= '0;
            e_seg <= '0; e_dp <= 1'b0; e_dig <= '0;
        end else begin
            {e_dig, e_dp, e_seg} <= expect_at(n, m_data, m_dp, m_blank);
            n <= n + 1;
            if (load) begin
                m_data <= data; m_dp <= dp_in; m_blank <= blank;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [6:0] s_lo;
        logic [3:0] d_lo;
        logic       p_lo;
        s_lo = ~e_seg;
        d_lo = ~e_dig;
        p_lo = ~e_dp;
        chk("seg_lo", 32'(seg_a), 32'(s_lo));
        chk("dp_lo",  32'(dp_a),  32'(p_lo));
        chk("dig_lo", 32'(dig_a), 32'(d_lo));
        chk("seg_hi", 32'(seg_b), 32'(e_seg));
        chk("dp_hi",  32'(dp_b),  32'(e_dp));
        chk("dig_hi", 32'(dig_b), 32'(e_dig));
        chk("idx_lo", 32'(idx_a), 32'((n / DIV) % D));
        chk("idx_hi", 32'(idx_b), 32'((n / DIV) % D));
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data = d; dp_in = p; blank = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_idle_pins(input string tag);
        chk({tag, "_seg"}, 32'(seg_a), 32'h7F);
        chk({tag, "_dp"},  32'(dp_a),  32'h1);
        chk({tag, "_dig"}, 32'(dig_a), 32'hF);
        chk({tag, "_idx"}, 32'(idx_a), 32'h0);
        chk({tag, "_seg_hi"}, 32'(seg_b), 32'h00);
        chk({tag, "_dig_hi"}, 32'(dig_b), 32'h0);
    endtask

    initial begin
        int guard;

        // Reset held, with load requested (must be ignored).
        data = 16'hFFFF; load = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle_pins("rst_hold");
        end
        load = 1'b0; data = '0;
        rst = 1'b0;
        repeat (4) tick();

        // Scan order with a full word; 40 cycles covers the 3 -> 0 wrap.
        do_load(16'h12AF, 4'h0, 4'h0);
        repeat (40) tick();

        // Asynchronous reset in the middle of an active slot.
        guard = 0;
        while ((n % DIV) != 5 && guard < 16) begin tick(); guard++; end
        chk("phase_wait_rst", 32'(guard < 16), 32'h1);
        #2 rst = 1'b1;
        #1 check_idle_pins("rst_async");
        repeat (2) begin
            @(negedge clk);
            check_idle_pins("rst_mid");
        end
        rst = 1'b0;

        // Leading-zero suppression, then an all-zero word.
        do_load(16'h0005, 4'h0, 4'h0);
        repeat (34) tick();
        do_load(16'h0000, 4'h0, 4'h0);
        repeat (34) tick();

        // Decimal point stops suppression; blank darkens digit 0.
        do_load(16'h0005, 4'b0100, 4'b0001);
        repeat (34) tick();

        // Load latency: a load in the digit-0 window shows one cycle later.
        do_load(16'h0001, 4'h0, 4'h0);
        guard = 0;
        while ((n % (DIV * D)) != 4 && guard < 64) begin tick(); guard++; end
        chk("phase_wait_load", 32'(guard < 64), 32'h1);
        data = 16'h0009; load = 1'b1;
        tick();
        chk("load_old_seg", 32'(seg_a), 32'h4F);
        load = 1'b0;
        tick();
        chk("load_new_seg", 32'(seg_a), 32'h04);

        // Load on the prescaler wrap edge updates shadow and slot together.
        guard = 0;
        while ((n % DIV) != 7 && guard < 16) begin tick(); guard++; end
        chk("phase_wait_wrap", 32'(guard < 16), 32'h1);
        do_load(16'h3210, 4'b1000, 4'h0);
        repeat (34) tick();

        // Polarity check value for the active-high instance.
        do_load(16'h0008, 4'h0, 4'h0);
        repeat (34) tick();

        // Randomized loads at random times, biased towards leading zeros.
        repeat (40) begin
            logic [15:0] rd;
            rd = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
            do_load(rd, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
            repeat ($urandom_range(0, 20)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
